multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Moore FSM plus combinational decoders that sequence a multicycle RV32I datapath. Instruction and data share one memory port, and each instruction takes 3–5 cycles.
- Replaces the single-cycle controller for the multicycle core variant.
- Drives every datapath mux select and write enable from the registered instruction's fields and the ALU zero flag.

Parameters:
- RESET_STATE, S_FETCH, state entered on reset (kept for bring-up; no other value is legal in production).

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- op  in  7  instr[6:0] from the instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result
- MemWrite  out  1  data store enable
- IRWrite  out  1  instruction register and OldPC enable
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4
- ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- RegWrite  out  1  register-file write enable
- ALUControl  out  4  ALU operation
- retire  out  1  high during the final cycle of each instruction
- illegal  out  1  high while in TRAP

Behaviour:
- Reset, while reset = 0:
  - state = S_FETCH.
  - PCWrite, IRWrite, MemWrite, RegWrite and retire are forced to 0.
  - Mux selects show S_FETCH values; illegal = 0.
- After reset releases, the first rising edge executes FETCH.
- Unlisted outputs in each state are 0; ALUOp is internal.
- States, outputs and next state:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1 -> DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target) -> next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 with funct3 in {000, 001} -> BRANCH
    - 1101111 -> JAL
    - anything else -> TRAP
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00 -> MEMREAD if op[5]=0, MEMWRITE if op[5]=1.
  - MEMREAD: AdrSrc=1, ResultSrc=00 -> MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1, retire=1 -> FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, retire=1 -> FETCH.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1, retire=1 -> FETCH.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, retire=1 -> FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 -> ALUWB (link write).
  - TRAP: all enables 0, illegal=1; remains in TRAP until reset.
- Branch resolution:
  - PCWrite = PCUpdate | (Branch & (zero ^ funct3[0])).
  - beq takes the branch when zero=1; bne when zero=0.
- ImmSrc decodes from op in every state:
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - otherwise -> 00
- ALU decoder:
  - ALUOp 00 -> ADD; 01 -> SUB.
  - ALUOp 10 decodes funct3:
    - 000 -> SUB if op[5] & funct7b5, else ADD
    - 001 -> SLL; 010 -> SLT; 011 -> SLTU; 100 -> XOR
    - 101 -> SRA if funct7b5, else SRL
    - 110 -> OR; 111 -> AND
- Cycle counts:
  - lw: 5
  - sw, R-type, I-type, jal: 4
  - branch: 3
- retire pulses exactly once per completed instruction and never in TRAP.
- Illegal opcodes are detected only in DECODE; no write enable is ever asserted for them.
- Reset asserted mid-instruction:
  - Outputs are gated on the same cycle, with no partial write.
  - Execution resumes at FETCH after release.
- State encoding is free. The state register is the only storage.

Decomposition:
- Package riscv_mc_pkg:
  - state_t enum
  - alucontrol_t with ALU_ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLT=0101, SLL=0110, SRL=0111, SRA=1000, SLTU=1001
  - opcode constants OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL
  - mux-select constants for AdrSrc, ResultSrc, ALUSrcA, ALUSrcB and ImmSrc
- Sub-module aludec (ALUOp, funct3, op5, funct7b5 -> ALUControl), shared with the single-cycle controller.
- FSM and ImmSrc decode stay in multicycle_controller.

Test Plan:
- Release reset with op=0000011 (lw), funct3=010:
  - Expect states FETCH, DECODE, MEMADR, MEMREAD, MEMWB.
  - IRWrite=1 in cycle 1 only; RegWrite=1 with ResultSrc=01 in cycle 5 only.
  - retire=1 in cycle 5; MemWrite=0 throughout.
- sw (0100011): in cycle 4, MemWrite=1 and AdrSrc=1; ImmSrc=01 in all cycles; RegWrite is never asserted.
- R-type sub (op=0110011, funct3=000, funct7b5=1):
  - ALUControl=0001 in EXECR, RegWrite=1 in ALUWB.
  - Repeat with funct3=101, funct7b5=1: ALUControl=1000.
- Branch with op=1100011:
  - beq with zero=1 -> PCWrite=1 in cycle 3.
  - beq with zero=0 -> PCWrite=0.
  - bne with zero=0 -> PCWrite=1.
  - Each case takes 3 cycles with retire=1 in cycle 3.
- op=1111111, or branch with funct3=100:
  - Enters TRAP after DECODE; illegal=1 and stays high over 20 cycles.
  - All enables 0; reset low returns to FETCH with illegal=0.
- Reset asserted low during MEMWRITE:
  - MemWrite drops to 0 that cycle without a clock edge.
  - After release, the FETCH outputs appear and a jal completes in 4 cycles (PCWrite in cycles 1 and 3, RegWrite in cycle 4).

Source files
------------

// File: rtl/riscv_mc_pkg.sv
// Shared types and encodings for the multicycle RV32I controller.
// The single-cycle controller also uses the ALU control encoding and the opcode constants.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLL  = 4'b0110,
    ALU_SRL  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alucontrol_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_RESULT = 1'b1;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_controller_aludec.sv
// ALU decoder: maps ALUOp and instruction fields onto an ALU operation.
// The single-cycle controller instantiates this same decoder.
module aludec
  import riscv_mc_pkg::*;
(
  input  logic [1:0]  aluop_i,
  input  logic [2:0]  funct3_i,
  input  logic        op5_i,
  input  logic        funct7b5_i,
  output alucontrol_t alucontrol_o
);

  always_comb begin
    alucontrol_o = ALU_ADD;
    case (aluop_i)
      ALUOP_ADD: alucontrol_o = ALU_ADD;
      ALUOP_SUB: alucontrol_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // Only R-type can subtract; addi with imm[10] set must still add.
          3'b000:  alucontrol_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  alucontrol_o = ALU_SLL;
          3'b010:  alucontrol_o = ALU_SLT;
          3'b011:  alucontrol_o = ALU_SLTU;
          3'b100:  alucontrol_o = ALU_XOR;
          3'b101:  alucontrol_o = funct7b5_i ? ALU_SRA : ALU_SRL;
          3'b110:  alucontrol_o = ALU_OR;
          default: alucontrol_o = ALU_AND;
        endcase
      end
      default: alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore controller sequencing a shared-memory multicycle RV32I datapath.
// Every write enable is gated by reset, so asserting reset mid-instruction cannot cause a partial write.
module multicycle_controller
  import riscv_mc_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [3:0] ALUControl,
  output logic       retire,
  output logic       illegal
);

  state_t      state_q, state_d;
  logic [1:0]  aluOp;
  logic        pcUpdate, branch, irWrite, memWrite, regWrite, retireRaw, illegalRaw;
  alucontrol_t aluControl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= RESET_STATE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    AdrSrc     = ADR_PC;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    aluOp      = ALUOP_ADD;
    pcUpdate   = 1'b0;
    branch     = 1'b0;
    irWrite    = 1'b0;
    memWrite   = 1'b0;
    regWrite   = 1'b0;
    retireRaw  = 1'b0;
    illegalRaw = 1'b0;
    case (state_q)
      S_FETCH: begin
        irWrite   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        pcUpdate  = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        // The ALU precomputes OldPC + imm so a branch or jal finds its target in ALUOut.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BRANCH:         state_d = (funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc  = ADR_RESULT;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        regWrite  = 1'b1;
        retireRaw = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc    = ADR_RESULT;
        memWrite  = 1'b1;
        retireRaw = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        aluOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        aluOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regWrite  = 1'b1;
        retireRaw = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA   = SRCA_RS1;
        aluOp     = ALUOP_SUB;
        branch    = 1'b1;
        retireRaw = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target held in ALUOut while the ALU forms the link value OldPC + 4.
        ALUSrcA  = SRCA_OLDPC;
        ALUSrcB  = SRCB_FOUR;
        pcUpdate = 1'b1;
        state_d  = S_ALUWB;
      end
      S_TRAP: begin
        illegalRaw = 1'b1;
        state_d    = S_TRAP;
      end
      default: state_d = RESET_STATE;
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE:  ImmSrc = IMM_S;
      OP_BRANCH: ImmSrc = IMM_B;
      OP_JAL:    ImmSrc = IMM_J;
      default:   ImmSrc = IMM_I;
    endcase
  end

  aludec u_aludec (
    .aluop_i      (aluOp),
    .funct3_i     (funct3),
    .op5_i        (op[5]),
    .funct7b5_i   (funct7b5),
    .alucontrol_o (aluControl)
  );

  assign ALUControl = aluControl;
  assign PCWrite    = reset & (pcUpdate | (branch & (zero ^ funct3[0])));
  assign IRWrite    = reset & irWrite;
  assign MemWrite   = reset & memWrite;
  assign RegWrite   = reset & regWrite;
  assign retire     = reset & retireRaw;
  assign illegal    = reset & illegalRaw;

endmodule

// File: tb/tb_multicycle_controller.sv
// Cycle-by-cycle directed checks of the multicycle controller outputs.
// Each record is one clock cycle: inputs held during the cycle and the full expected output word.
module tb_multicycle_controller;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RTY  = 7'b0110011;
  localparam logic [6:0] ITY  = 7'b0010011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] BAD  = 7'b1111111;

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic [18:0] exp;
  } vec_t;

  logic       clk, reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, retire, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [3:0] ALUControl;

  int   assertCount = 0;
  int   failCount   = 0;
  vec_t vecs[$];

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .RegWrite   (RegWrite),
    .ALUControl (ALUControl),
    .retire     (retire),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output word order: PCWrite AdrSrc MemWrite IRWrite ResultSrc ALUSrcA ALUSrcB ImmSrc RegWrite ALUControl retire illegal
  function automatic logic [18:0] mk(input logic pcw, input logic adr, input logic memw, input logic irw,
                                     input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] imm, input logic regw, input logic [3:0] aluc,
                                     input logic ret, input logic ill);
    return {pcw, adr, memw, irw, rs, sa, sb, imm, regw, aluc, ret, ill};
  endfunction

  task automatic addVec(input string n, input logic [6:0] o, input logic [2:0] f, input logic f7b,
                        input logic z, input logic [18:0] e);
    vec_t v;
    v.name = n; v.op = o; v.f3 = f; v.f7 = f7b; v.z = z; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f, input logic f7b, input logic z);
    op       = o;
    funct3   = f;
    funct7b5 = f7b;
    zero     = z;
  endtask

  task automatic checkOutput(input string n, input logic [18:0] e);
    logic [18:0] actual;
    actual = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
              RegWrite, ALUControl, retire, illegal};
    assertCount++;
    if (actual !== e) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", n, actual, e);
    end
  endtask

  // Entered just after a falling edge; leaves just after the next falling edge.
  task automatic runCycle(input vec_t v);
    applyStimulus(v.op, v.f3, v.f7, v.z);
    #1;
    checkOutput(v.name, v.exp);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic runTrap(input string n, input logic [6:0] o, input logic [2:0] f, input logic [1:0] imm);
    vec_t v;
    v.op = o; v.f3 = f; v.f7 = 1'b0; v.z = 1'b0;
    v.name = {n, "_fetch"};  v.exp = mk(1,0,0,1,2'b10,2'b00,2'b10,imm,0,4'h0,0,0); runCycle(v);
    v.name = {n, "_decode"}; v.exp = mk(0,0,0,0,2'b00,2'b01,2'b01,imm,0,4'h0,0,0); runCycle(v);
    v.exp = mk(0,0,0,0,2'b00,2'b00,2'b00,imm,0,4'h0,0,1);
    for (int i = 0; i < 20; i++) begin
      v.name = $sformatf("%s_trap%0d", n, i);
      runCycle(v);
    end
    reset = 1'b0;
    #1;
    checkOutput({n, "_reset"}, mk(0,0,0,0,2'b10,2'b00,2'b10,imm,0,4'h0,0,0));
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    vec_t v;
    reset = 1'b0;
    applyStimulus(LW, 3'b010, 1'b0, 1'b0);

    addVec("lw_fetch",   LW, 3'b010, 0, 0, mk(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,4'h0,0,0));
    addVec("lw_decode",  LW, 3'b010, 0, 0, mk(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,4'h0,0,0));
    addVec("lw_memadr",  LW, 3'b010, 0, 0, mk(0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,4'h0,0,0));
    addVec("lw_memread", LW, 3'b010, 0, 0, mk(0,1,0,0,2'b00,2'b00,2'b00,2'b00,0,4'h0,0,0));
    addVec("lw_memwb",   LW, 3'b010, 0, 0, mk(0,0,0,0,2'b01,2'b00,2'b00,2'b00,1,4'h0,1,0));
    addVec("sw_fetch",   SW, 3'b010, 0, 0, mk(1,0,0,1,2'b10,2'b00,2'b10,2'b01,0,4'h0,0,0));
    addVec("sw_decode",  SW, 3'b010, 0, 0, mk(0,0,0,0,2'b00,2'b01,2'b01,2'b01,0,4'h0,0,0));
    addVec("sw_memadr",  SW, 3'b010, 0, 0, mk(0,0,0,0,2'b00,2'b10,2'b01,2'b01,0,4'h0,0,0));
    addVec("sw_memwr",   SW, 3'b010, 0, 0, mk(0,1,1,0,2'b00,2'b00,2'b00,2'b01,0,4'h0,1,0));
    addVec("sub_fetch",  RTY, 3'b000, 1, 0, mk(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,4'h0,0,0));
    addVec("sub_decode", RTY, 3'b000, 1, 0, mk(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,4'h0,0,0));
    addVec("sub_execr",  RTY, 3'b000, 1, 0, mk(0,0,0,0,2'b00,2'b10,2'b00,2'b00,0,4'h1,0,0));
    addVec("sub_aluwb",  RTY, 3'b000, 1, 0, mk(0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,4'h0,1,0));
    addVec("sra_fetch",  RTY, 3'b101, 1, 0, mk(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,4'h0,0,0));
    addVec("sra_decode", RTY, 3'b101, 1, 0, mk(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,4'h0,0,0));
    addVec("sra_execr",  RTY, 3'b101, 1, 0, mk(0,0,0,0,2'b00,2'b10,2'b00,2'b00,0,4'h8,0,0));
    addVec("sra_aluwb",  RTY, 3'b101, 1, 0, mk(0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,4'h0,1,0));
    addVec("addi_fetch", ITY, 3'b000, 1, 0, mk(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,4'h0,0,0));
    addVec("addi_decode",ITY, 3'b000, 1, 0, mk(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,4'h0,0,0));
    addVec("addi_execi", ITY, 3'b000, 1, 0, mk(0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,4'h0,0,0));
    addVec("addi_aluwb", ITY, 3'b000, 1, 0, mk(0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,4'h0,1,0));
    addVec("sltiu_fetch",ITY, 3'b011, 0, 0, mk(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,4'h0,0,0));
    addVec("sltiu_dec",  ITY, 3'b011, 0, 0, mk(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,4'h0,0,0));
    addVec("sltiu_execi",ITY, 3'b011, 0, 0, mk(0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,4'h9,0,0));
    addVec("sltiu_aluwb",ITY, 3'b011, 0, 0, mk(0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,4'h0,1,0));
    addVec("beqT_fetch", BR, 3'b000, 0, 1, mk(1,0,0,1,2'b10,2'b00,2'b10,2'b10,0,4'h0,0,0));
    addVec("beqT_decode",BR, 3'b000, 0, 1, mk(0,0,0,0,2'b00,2'b01,2'b01,2'b10,0,4'h0,0,0));
    addVec("beqT_branch",BR, 3'b000, 0, 1, mk(1,0,0,0,2'b00,2'b10,2'b00,2'b10,0,4'h1,1,0));
    addVec("beqN_fetch", BR, 3'b000, 0, 0, mk(1,0,0,1,2'b10,2'b00,2'b10,2'b10,0,4'h0,0,0));
    addVec("beqN_decode",BR, 3'b000, 0, 0, mk(0,0,0,0,2'b00,2'b01,2'b01,2'b10,0,4'h0,0,0));
    addVec("beqN_branch",BR, 3'b000, 0, 0, mk(0,0,0,0,2'b00,2'b10,2'b00,2'b10,0,4'h1,1,0));
    addVec("bneT_fetch", BR, 3'b001, 0, 0, mk(1,0,0,1,2'b10,2'b00,2'b10,2'b10,0,4'h0,0,0));
    addVec("bneT_decode",BR, 3'b001, 0, 0, mk(0,0,0,0,2'b00,2'b01,2'b01,2'b10,0,4'h0,0,0));
    addVec("bneT_branch",BR, 3'b001, 0, 0, mk(1,0,0,0,2'b00,2'b10,2'b00,2'b10,0,4'h1,1,0));
    addVec("bneN_fetch", BR, 3'b001, 0, 1, mk(1,0,0,1,2'b10,2'b00,2'b10,2'b10,0,4'h0,0,0));
    addVec("bneN_decode",BR, 3'b001, 0, 1, mk(0,0,0,0,2'b00,2'b01,2'b01,2'b10,0,4'h0,0,0));
    addVec("bneN_branch",BR, 3'b001, 0, 1, mk(0,0,0,0,2'b00,2'b10,2'b00,2'b10,0,4'h1,1,0));
    addVec("jal_fetch",  JAL, 3'b000, 0, 0, mk(1,0,0,1,2'b10,2'b00,2'b10,2'b11,0,4'h0,0,0));
    addVec("jal_decode", JAL, 3'b000, 0, 0, mk(0,0,0,0,2'b00,2'b01,2'b01,2'b11,0,4'h0,0,0));
    addVec("jal_jal",    JAL, 3'b000, 0, 0, mk(1,0,0,0,2'b00,2'b01,2'b10,2'b11,0,4'h0,0,0));
    addVec("jal_aluwb",  JAL, 3'b000, 0, 0, mk(0,0,0,0,2'b00,2'b00,2'b00,2'b11,1,4'h0,1,0));

    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_state", mk(0,0,0,0,2'b10,2'b00,2'b10,2'b00,0,4'h0,0,0));
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) runCycle(vecs[i]);

    runTrap("badop", BAD, 3'b000, 2'b00);
    runTrap("badbr", BR, 3'b100, 2'b10);

    // Reset lands in MEMWRITE: the store must be withdrawn immediately, then a jal runs cleanly.
    v.op = SW; v.f3 = 3'b010; v.f7 = 1'b0; v.z = 1'b0;
    for (int i = 5; i < 8; i++) begin
      v.name = {"rst_", vecs[i].name};
      v.exp  = vecs[i].exp;
      runCycle(v);
    end
    applyStimulus(SW, 3'b010, 1'b0, 1'b0);
    #1;
    checkOutput("rst_sw_memwr", mk(0,1,1,0,2'b00,2'b00,2'b00,2'b01,0,4'h0,1,0));
    reset = 1'b0;
    #1;
    checkOutput("rst_during_memwr", mk(0,0,0,0,2'b10,2'b00,2'b10,2'b01,0,4'h0,0,0));
    @(negedge clk);
    reset = 1'b1;
    for (int i = vecs.size() - 4; i < vecs.size(); i++) runCycle(vecs[i]);
    v.op = JAL; v.f3 = 3'b000; v.name = "post_jal_fetch";
    v.exp = mk(1,0,0,1,2'b10,2'b00,2'b10,2'b11,0,4'h0,0,0);
    runCycle(v);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
